// File: rtl/windower_pad.sv
// Streaming 1-D sliding-window generator: T samples in per beat, one window of
// T+K-1 samples out per beat, image edges padded with zeros or the edge sample.
module windower_pad #(
   parameter int NO_CH         = 8,
   parameter int LOG2_IMG_SIZE = 7,
   parameter int THROUGHPUT    = 1,
   parameter int KERNEL        = 3,
   parameter int PAD_MODE      = 0
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      vld_in,
   output logic                                      rdy_in,
   input  logic [THROUGHPUT-1:0][NO_CH-1:0]          data_in,
   output logic                                      vld_out,
   input  logic                                      rdy_out,
   output logic [THROUGHPUT+KERNEL-2:0][NO_CH-1:0]   data_out
);

   localparam int T  = THROUGHPUT;
   localparam int P  = (KERNEL - 1) / 2;
   localparam int W  = T + KERNEL - 1;
   localparam int CW = LOG2_IMG_SIZE - $clog2(T);

   typedef logic [T-1:0][NO_CH-1:0] beat_t;
   typedef logic [P-1:0][NO_CH-1:0] edge_t;
   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   edge_t         prev_q;   // newest P samples of the beat before cur_q
   beat_t         cur_q;
   edge_t         lead_pad, tail_pad, nxt_edge;
   logic [W-1:0][NO_CH-1:0] window;
   logic          out_free, accept, load;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      out_free  = !vld_out || rdy_out;
      rdy_in    = out_free && (state != FLUSH);
      accept    = vld_in && rdy_in;
      lead_pad  = (PAD_MODE == 1) ? {P{data_in[T-1]}} : '0;
      tail_pad  = (PAD_MODE == 1) ? {P{cur_q[0]}}     : '0;
      nxt_edge  = (state == FLUSH) ? tail_pad : data_in[T-1 -: P];
      window    = {prev_q, cur_q, nxt_edge};
      load      = (state == RUN && accept) || (state == FLUSH && out_free);
      state_nxt = state;
      case (state)
         FILL:    if (accept) state_nxt = RUN;
         RUN:     if (accept && cnt == '1) state_nxt = FLUSH;
         FLUSH:   if (out_free) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FILL;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) cnt <= cnt + 1'b1;
      end
   end

   // NOTE: the history is reset so a mid-image reset cannot leak old samples
   // into the leading pad of the next image.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q <= '0;
         cur_q  <= '0;
      end else if (accept) begin
         prev_q <= (state == FILL) ? lead_pad : cur_q[P-1:0];
         cur_q  <= data_in;
      end
   end

   // Output register only loads when free, so data holds through a stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_out  <= 1'b0;
         data_out <= '0;
      end else if (load) begin
         vld_out  <= 1'b1;
         data_out <= window;
      end else if (rdy_out) begin
         vld_out  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_windower_pad.sv
// Bench for windower_pad: three instances (T1/K3 zero, T2/K5 zero, T2/K5 replicate)
// checked against hand vectors and an index-based golden model.
module tb_windower_pad;
   localparam int N = 128;

   typedef logic [5:0][7:0] w6_t;
   typedef struct {
      int    sel;
      int    idx;
      w6_t   exp;
      string name;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            vld_a, rdy_in_a, vld_out_a, rdy_out_a;
   logic [0:0][7:0] din_a;
   logic [2:0][7:0] dout_a;
   logic            vld_b, rdy_in_b, rdy_in_c, vld_out_b, vld_out_c, rdy_out_b;
   logic [1:0][7:0] din_b;
   logic [5:0][7:0] dout_b, dout_c;

   windower_pad u_a (
      .clk(clk), .rst(rst), .vld_in(vld_a), .rdy_in(rdy_in_a), .data_in(din_a),
      .vld_out(vld_out_a), .rdy_out(rdy_out_a), .data_out(dout_a));

   windower_pad #(.THROUGHPUT(2), .KERNEL(5), .PAD_MODE(0)) u_b (
      .clk(clk), .rst(rst), .vld_in(vld_b), .rdy_in(rdy_in_b), .data_in(din_b),
      .vld_out(vld_out_b), .rdy_out(rdy_out_b), .data_out(dout_b));

   windower_pad #(.THROUGHPUT(2), .KERNEL(5), .PAD_MODE(1)) u_c (
      .clk(clk), .rst(rst), .vld_in(vld_b), .rdy_in(rdy_in_c), .data_in(din_b),
      .vld_out(vld_out_c), .rdy_out(rdy_out_b), .data_out(dout_c));

   int   n_checks = 0;
   int   n_fail   = 0;
   w6_t  cap_a[$], cap_b[$], cap_c[$];
   bit   hold[3];
   w6_t  prev[3];
   int   offs_a[2], offs_b[2];
   int   stall_a, stall_b, stall_beat_a, stall_beat_b, t0_a, t1_a, t0_b, t1_b;
   vec_t tbl[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic w6_t mk6(input int a0, a1, a2, a3, a4, a5);
      w6_t r;
      r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2);
      r[3] = 8'(a3); r[4] = 8'(a4); r[5] = 8'(a5);
      return r;
   endfunction

   // Golden model: resolve each tap to an absolute sample index, then pad.
   function automatic w6_t model(input int t, input int k, input bit rep, input int off, input int w);
      int  p = (k - 1) / 2;
      w6_t r = '0;
      for (int j = 0; j < t + k - 1; j++) begin
         int idx;
         int s;
         idx = w * t + t - 1 + p - j;
         if (idx < 0)       s = rep ? off : 0;
         else if (idx >= N) s = rep ? off + N - 1 : 0;
         else               s = off + idx;
         r[j] = 8'(s);
      end
      return r;
   endfunction

   task automatic mon(input int s, input logic vo, input logic ro, input logic ri, input w6_t d);
      if (hold[s]) check($sformatf("stable_%0d", s), {vo, d}, {1'b1, prev[s]});
      if (vo && !ro) check($sformatf("rdy_in_stall_%0d", s), ri, 1'b0);
      if (vo && ro) begin
         case (s)
            0:       cap_a.push_back(d);
            1:       cap_b.push_back(d);
            default: cap_c.push_back(d);
         endcase
      end
      hold[s] = vo && !ro;
      prev[s] = d;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         hold[0] = 1'b0; hold[1] = 1'b0; hold[2] = 1'b0;
      end else begin
         mon(0, vld_out_a, rdy_out_a, rdy_in_a, {24'd0, dout_a});
         mon(1, vld_out_b, rdy_out_b, rdy_in_b, dout_b);
         mon(2, vld_out_c, rdy_out_b, rdy_in_c, dout_c);
      end
   end

   // Drives n_a beats into A and n_b beats into B/C; entered and left at posedge+1.
   task automatic run_phase(input int n_a, input int n_b, input bit rnd);
      int ba  = 0;
      int bb  = 0;
      int cyc = 0;
      bit acc_a, acc_b;
      stall_a = 0; stall_b = 0; stall_beat_a = -1; stall_beat_b = -1;
      t0_a = -1; t1_a = -1; t0_b = -1; t1_b = -1;
      while ((ba < n_a || bb < n_b) && cyc < 3000) begin
         vld_a     = (ba < n_a) && (!rnd || $urandom_range(0, 3) != 0);
         din_a[0]  = 8'(offs_a[(ba / N) % 2] + ba % N);
         vld_b     = (bb < n_b) && (!rnd || $urandom_range(0, 3) != 0);
         din_b[0]  = 8'(offs_b[(bb / (N / 2)) % 2] + 2 * (bb % (N / 2)) + 1);
         din_b[1]  = 8'(offs_b[(bb / (N / 2)) % 2] + 2 * (bb % (N / 2)));
         rdy_out_a = !rnd || ($urandom_range(0, 2) != 0);
         rdy_out_b = !rnd || ($urandom_range(0, 2) != 0);
         @(negedge clk);
         acc_a = vld_a && rdy_in_a;
         acc_b = vld_b && rdy_in_b;
         if (vld_a && !rdy_in_a) begin stall_a++; stall_beat_a = ba; end
         if (vld_b && !rdy_in_b) begin stall_b++; stall_beat_b = bb; end
         if (acc_a && ba == 0) t0_a = cyc;
         if (acc_a && ba == N) t1_a = cyc;
         if (acc_b && bb == 0) t0_b = cyc;
         if (acc_b && bb == N / 2) t1_b = cyc;
         @(posedge clk); #1;
         if (acc_a) ba++;
         if (acc_b) bb++;
         cyc++;
      end
      check("phase_timeout", cyc < 3000, 1'b1);
      vld_a = 1'b0;
      vld_b = 1'b0;
   endtask

   task automatic drain();
      vld_a = 1'b0; vld_b = 1'b0; rdy_out_a = 1'b1; rdy_out_b = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic cmp_stream(input int s, input int t, input int k, input bit rep,
                             input int n_win, input int off0, input int off1);
      int m = N / t;
      int sz;
      sz = (s == 0) ? cap_a.size() : (s == 1) ? cap_b.size() : cap_c.size();
      check($sformatf("count_%0d", s), sz, n_win);
      for (int i = 0; i < sz && i < n_win; i++) begin
         w6_t got;
         got = (s == 0) ? cap_a[i] : (s == 1) ? cap_b[i] : cap_c[i];
         check($sformatf("stream_%0d_win%0d", s, i), got,
               model(t, k, rep, ((i / m) == 0) ? off0 : off1, i % m));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{0, 0,   mk6(1, 0, 0, 0, 0, 0),           "a_w0"};
      tbl[1]  = '{0, 5,   mk6(6, 5, 4, 0, 0, 0),           "a_w5"};
      tbl[2]  = '{0, 127, mk6(0, 127, 126, 0, 0, 0),       "a_w127"};
      tbl[3]  = '{0, 128, mk6(51, 50, 0, 0, 0, 0),         "a_img1_w0"};
      tbl[4]  = '{0, 255, mk6(0, 177, 176, 0, 0, 0),       "a_img1_w127"};
      tbl[5]  = '{1, 0,   mk6(3, 2, 1, 0, 0, 0),           "b_w0"};
      tbl[6]  = '{1, 63,  mk6(0, 0, 127, 126, 125, 124),   "b_w63"};
      tbl[7]  = '{1, 64,  mk6(13, 12, 11, 10, 0, 0),       "b_img1_w0"};
      tbl[8]  = '{1, 127, mk6(0, 0, 137, 136, 135, 134),   "b_img1_w63"};
      tbl[9]  = '{2, 0,   mk6(3, 2, 1, 0, 0, 0),           "c_w0"};
      tbl[10] = '{2, 63,  mk6(127, 127, 127, 126, 125, 124), "c_w63"};
      tbl[11] = '{2, 64,  mk6(13, 12, 11, 10, 10, 10),     "c_img1_w0"};
      tbl[12] = '{2, 127, mk6(137, 137, 137, 136, 135, 134), "c_img1_w63"};

      rst = 1'b0; vld_a = 1'b0; vld_b = 1'b0; din_a = '0; din_b = '0;
      rdy_out_a = 1'b1; rdy_out_b = 1'b1;
      #12;
      check("rst_vld_a", vld_out_a, 1'b0);
      check("rst_dout_a", dout_a, '0);
      check("rst_vld_b", vld_out_b, 1'b0);
      check("rst_dout_b", dout_b, '0);
      check("rst_vld_c", vld_out_c, 1'b0);
      check("rst_dout_c", dout_c, '0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("rdy_after_rst_a", rdy_in_a, 1'b1);
      check("rdy_after_rst_b", rdy_in_b, 1'b1);
      @(posedge clk); #1;

      // Two back-to-back images, continuous input, no backpressure.
      offs_a = '{0, 50};
      offs_b = '{0, 10};
      run_phase(2 * N, N, 1'b0);
      check("a_stall_cycles", stall_a, 1);
      check("a_stall_beat", stall_beat_a, N);
      check("a_image_period", t1_a - t0_a, N + 1);
      check("b_stall_cycles", stall_b, 1);
      check("b_stall_beat", stall_beat_b, N / 2);
      check("b_image_period", t1_b - t0_b, N / 2 + 1);
      drain();
      for (int i = 0; i < 13; i++) begin
         w6_t got;
         case (tbl[i].sel)
            0:       got = (tbl[i].idx < cap_a.size()) ? cap_a[tbl[i].idx] : '0;
            1:       got = (tbl[i].idx < cap_b.size()) ? cap_b[tbl[i].idx] : '0;
            default: got = (tbl[i].idx < cap_c.size()) ? cap_c[tbl[i].idx] : '0;
         endcase
         check(tbl[i].name, got, tbl[i].exp);
      end
      cmp_stream(0, 1, 3, 1'b0, 2 * N, 0, 50);
      cmp_stream(1, 2, 5, 1'b0, N, 0, 10);
      cmp_stream(2, 2, 5, 1'b1, N, 0, 10);

      // Random input gaps and random downstream backpressure.
      cap_a.delete(); cap_b.delete(); cap_c.delete();
      offs_a = '{3, 3};
      offs_b = '{20, 20};
      run_phase(N, N / 2, 1'b1);
      drain();
      cmp_stream(0, 1, 3, 1'b0, N, 3, 3);
      cmp_stream(1, 2, 5, 1'b0, N / 2, 20, 20);
      cmp_stream(2, 2, 5, 1'b1, N / 2, 20, 20);

      // Reset in the middle of an image.
      cap_a.delete();
      offs_a = '{0, 0};
      run_phase(40, 0, 1'b0);
      check("pre_reset_vld_a", vld_out_a, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_vld_a", vld_out_a, 1'b0);
      check("async_rst_dout_a", dout_a, '0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      cap_a.delete();
      offs_a = '{7, 7};
      run_phase(N, 0, 1'b0);
      drain();
      cmp_stream(0, 1, 3, 1'b0, N, 7, 7);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/windower_pad.md
# windower_pad

Streaming 1-D sliding-window generator for the conv front end. It accepts THROUGHPUT samples per beat from an image of 2^LOG2_IMG_SIZE samples and emits one window of THROUGHPUT+KERNEL-1 samples per beat, padding image boundaries with zeros or the replicated edge sample. This is the parametrised successor of the fixed 3-tap zero-pad windower: kernel width is a parameter, padding mode is selectable, and both sides carry a valid/ready handshake with backpressure.

## Interface
- NO_CH, 8: bits per sample.
- LOG2_IMG_SIZE, 7: image length N = 2^LOG2_IMG_SIZE samples.
- THROUGHPUT, 1: samples per input beat (T). Power of 2, T ≤ N/2.
- KERNEL, 3: window taps K. Odd, ≥ 3, P = (K-1)/2 ≤ T.
- PAD_MODE, 0: 0 = zero padding, 1 = replicate the nearest edge sample.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- vld_in  in  1  input beat valid.
- rdy_in  out  1  block accepts a beat this cycle.
- data_in  in  [NO_CH-1:0] x T  data_in[i] = sample base+T-1-i; index 0 is the newest sample.
- vld_out  out  1  window valid.
- rdy_out  in  1  downstream accepts the window.
- data_out  out  [NO_CH-1:0] x (T+K-1)  data_out[j] = sample base+T-1+P-j.

## Operation
- Beats per image M = N/T. Beat counter cnt is LOG2_IMG_SIZE-log2(T) bits and wraps at M. Input beat b carries samples bT..bT+T-1. Output beat b has base = bT.
- Accept when vld_in && rdy_in. rdy_in = (!vld_out || rdy_out) && state != FLUSH.
- The history buffer holds 3 input beats (prev, cur, next). This covers every window because P ≤ T.
- Out-of-range sample index (<0 or ≥N): PAD_MODE 0 gives 0. PAD_MODE 1 gives sample 0 on the leading edge and sample N-1 on the trailing edge.
- States:
  - FILL: after reset or image end. Accepting beat 0 stores it, emits nothing, and moves to RUN.
  - RUN: accepting beat b (1 ≤ b ≤ M-1) loads output window b-1. If b = M-1, move to FLUSH.
  - FLUSH: rdy_in = 0. When the output register is free (!vld_out || rdy_out), load window M-1 with the trailing pad and go to FILL.
- Output register: loaded only when free. It holds data_out and vld_out stable while vld_out && !rdy_out. vld_out drops after a handshake unless a new window loads in the same cycle.
- Windows never span images. Leading pad of image k+1 never uses samples of image k.
- Arithmetic: the index comparisons use a signed window offset. No arithmetic is performed on sample data.

## Timing
- Reset (rst = 0, asynchronous):
  - state = FILL, cnt = 0.
  - vld_out = 0, data_out = all zeros, history = zeros.
  - rdy_in = 1 from the first cycle after release.
- Latency: window b-1 has vld_out high the cycle after input beat b is accepted. Window M-1 is valid the cycle after FLUSH finds the register free, which is the cycle after the final beat if rdy_out = 1.
- Throughput: M windows per M+1 cycles per image with continuous input and rdy_out = 1. There is one bubble per image for the flush.
- Input gaps (vld_in = 0) in any state stall progress and do not change the buffer. A gap between images imposes no requirement.
- rdy_out low with vld_out high: rdy_in = 0, and no state, counter or buffer changes.
- Reset asserted mid-image discards partial state immediately. The next accepted beat is beat 0 of a new image.
- A handshake on output and input in the same cycle is legal and loads the next window without a bubble.

## Test plan
- Zero pad, defaults (T=1, K=3, N=128, ramp 0..127, rdy_out = 1):
  - window 0 = {1,0,0} for j = 0..2.
  - window 5 = {6,5,4}.
  - window 127 = {0,127,126}.
  - exactly 128 windows in 129 cycles.
- K=5, T=2, PAD_MODE 0, ramp:
  - window 0 = {3,2,1,0,0,0}.
  - window 63 = {0,0,127,126,125,124}.
- PAD_MODE 1, same configuration:
  - window 0 = {3,2,1,0,0,0}, where the pads equal sample 0 = 0.
  - with ramp offset +10, window 0 = {13,12,11,10,10,10}.
  - window 63 = {137,137,137,136,135,134}.
- Backpressure: rdy_out toggles pseudo-randomly and vld_in has random gaps.
  - windows match the golden model in order, with no loss or duplication.
  - data_out is stable while stalled.
  - rdy_in = 0 whenever vld_out && !rdy_out.
- Back-to-back images with continuous vld_in:
  - the beat after the final beat of image 0 is held by rdy_in = 0 for one cycle.
  - image 1 window 0 has zero leading pad and no image-0 samples.
- Reset mid-image (rst low for 3 cycles at beat 40):
  - vld_out = 0 and data_out = 0 asynchronously.
  - the next image produces correct windows starting at window 0.
